mem_bus_arbiter: RTL

Three-master arbiter that shares the single-ported platform memory bus (ADDR/BURST/REQ/WRB/WDATA/BSTROBE/RDATA/ACK/STALL) between the instruction fetch port, the data port and the page-table walker. Round-robin grant, held for a complete single or burst transaction, with a per-transaction ACK watchdog that releases a hung grant. Sits between the CPU-side bus ports and the memory controller, in place of a fixed-priority interconnect.

---
 rtl/mem_bus_arbiter_pkg.sv | 36 +++
 rtl/mem_bus_arbiter_if.sv | 18 +
 rtl/mem_bus_arbiter_rr_pick3.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the three-master memory bus arbiter: burst types,
// master indices, grant_id values and the FSM state type.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] BURST_SINGLE = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;

  localparam logic [1:0] ARB_I = 2'd0;
  localparam logic [1:0] ARB_D = 2'd1;
  localparam logic [1:0] ARB_W = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

  // Reserved encoding 11 is deliberately not a burst: it runs as one beat.
  function automatic logic is_burst(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[1]) return ARB_D;
    if (oh[2]) return ARB_W;
    return ARB_I;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == ARB_W) ? ARB_I : idx + 2'd1;
  endfunction

  function automatic logic [1:0] idx_to_grant(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One bus port: a requester drives through master, the responder through slave.
interface mem_bus_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  burst;
  logic        wrb;
  logic [31:0] wdata;
  logic [3:0]  bstrobe;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (output req, addr, burst, wrb, wdata, bstrobe,
                  input  rdata, ack, stall, err);
  modport slave  (input  req, addr, burst, wrb, wdata, bstrobe,
                  output rdata, ack, stall, err);
endinterface

// File: rtl/mem_bus_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: the first requester at or after ptr
// (order i -> d -> w -> i) receives the one-hot grant.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch, data
// and page-walker ports; grant held per transaction with an ACK watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  i_bus,
  mem_bus_arbiter_if.slave  d_bus,
  mem_bus_arbiter_if.slave  w_bus,
  mem_bus_arbiter_if.master mem_bus,
  output logic [1:0]        grant_id
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BEAT_W-1:0] BEATS_BURST  = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEATS_SINGLE = BEAT_W'(1);
  localparam logic [WD_W-1:0]   WD_LAST      = WD_W'(TIMEOUT_CYC - 1);

  logic [2:0]  req_a, wrb_a, ack_a, stall_a;
  logic [31:0] addr_a [3];
  logic [31:0] wdata_a [3];
  logic [31:0] rdata_a [3];
  logic [1:0]  burst_a [3];
  logic [3:0]  bstrobe_a [3];

  assign req_a   = {w_bus.req, d_bus.req, i_bus.req};
  assign wrb_a   = {w_bus.wrb, d_bus.wrb, i_bus.wrb};
  assign addr_a  = '{i_bus.addr, d_bus.addr, w_bus.addr};
  assign wdata_a = '{i_bus.wdata, d_bus.wdata, w_bus.wdata};
  assign burst_a = '{i_bus.burst, d_bus.burst, w_bus.burst};
  assign bstrobe_a = '{i_bus.bstrobe, d_bus.bstrobe, w_bus.bstrobe};

  arb_state_t        state_reg;
  logic [1:0]        gnt_reg, rr_ptr_reg, grant_id_reg, burst_reg;
  logic [BEAT_W-1:0] beats_reg;
  logic [WD_W-1:0]   wd_reg;
  logic [2:0]        err_reg;
  logic [2:0]        pick_oh;
  logic [1:0]        win_idx;
  logic              busy, gnt_req;

  rr_pick3 u_pick (
    .req (req_a),
    .ptr (rr_ptr_reg),
    .gnt (pick_oh)
  );

  assign win_idx = onehot_to_idx(pick_oh);
  assign busy    = (state_reg == ST_BUSY);
  assign gnt_req = busy && req_a[gnt_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= ARB_I;
      rr_ptr_reg   <= ARB_I;
      grant_id_reg <= GRANT_NONE;
      burst_reg    <= BURST_SINGLE;
      beats_reg    <= '0;
      wd_reg       <= '0;
      err_reg      <= '0;
    end else begin
      err_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (|req_a) begin
            state_reg    <= ST_BUSY;
            gnt_reg      <= win_idx;
            grant_id_reg <= idx_to_grant(win_idx);
            rr_ptr_reg   <= next_idx(win_idx);
            burst_reg    <= burst_a[win_idx];
            beats_reg    <= is_burst(burst_a[win_idx]) ? BEATS_BURST : BEATS_SINGLE;
            wd_reg       <= '0;
          end
        end
        default: begin
          // Priority: abort, then ACK, then watchdog -- so a final ACK beats a timeout.
          if (!gnt_req) begin
            state_reg    <= ST_IDLE;
            grant_id_reg <= GRANT_NONE;
          end else if (mem_bus.ack) begin
            wd_reg <= '0;
            if (beats_reg <= BEATS_SINGLE) begin
              state_reg    <= ST_IDLE;
              grant_id_reg <= GRANT_NONE;
              beats_reg    <= '0;
            end else begin
              beats_reg <= beats_reg - BEATS_SINGLE;
            end
          end else if (wd_reg >= WD_LAST) begin
            state_reg        <= ST_IDLE;
            grant_id_reg     <= GRANT_NONE;
            err_reg[gnt_reg] <= 1'b1;
            wd_reg           <= '0;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
      endcase
    end
  end

  assign mem_bus.req     = gnt_req;
  assign mem_bus.addr    = busy ? addr_a[gnt_reg]    : '0;
  assign mem_bus.burst   = busy ? burst_reg          : '0;
  assign mem_bus.wrb     = busy ? wrb_a[gnt_reg]     : 1'b0;
  assign mem_bus.wdata   = busy ? wdata_a[gnt_reg]   : '0;
  assign mem_bus.bstrobe = busy ? bstrobe_a[gnt_reg] : '0;
  assign grant_id        = grant_id_reg;

  // Stall of a waiting master is masked while rst is high so every output reads 0.
  for (genvar gi = 0; gi < 3; gi++) begin : g_resp
    logic granted;
    assign granted      = busy && (gnt_reg == 2'(gi));
    assign ack_a[gi]    = granted & mem_bus.ack;
    assign stall_a[gi]  = granted ? mem_bus.stall : (req_a[gi] & ~rst);
    assign rdata_a[gi]  = granted ? mem_bus.rdata : '0;
  end

  assign i_bus.rdata = rdata_a[0];
  assign d_bus.rdata = rdata_a[1];
  assign w_bus.rdata = rdata_a[2];
  assign i_bus.ack   = ack_a[0];
  assign d_bus.ack   = ack_a[1];
  assign w_bus.ack   = ack_a[2];
  assign i_bus.stall = stall_a[0];
  assign d_bus.stall = stall_a[1];
  assign w_bus.stall = stall_a[2];
  assign i_bus.err   = err_reg[0];
  assign d_bus.err   = err_reg[1];
  assign w_bus.err   = err_reg[2];

endmodule
